// File: rtl/mem_loader.sv
// Stream loader: takes a {base, count, data...} frame and writes it into RAM while holding the CPU.
// Define MEM_LOADER_VERIFY_EN to add a readback pass that compares RAM contents against the checksum.
module mem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              verify_err
);

`ifdef MEM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, GET_CNT, DATA, FLUSH, VERIFY, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, GET_CNT, DATA, FLUSH, DONE} state_t;
`endif

    // A count byte of zero means a full page of 2**ADDR_W bytes.
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_write_q, mem_write_d;
    logic [DATA_W-1:0]   checksum_q, checksum_d;
    logic [ADDR_W:0]     cnt_in;
    logic                xfer;

`ifdef MEM_LOADER_VERIFY_EN
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     vcnt_q, vcnt_d;
    logic [DATA_W-1:0]   rd_sum_q, rd_sum_d;
    logic                verify_err_q, verify_err_d;
`else
    logic                unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    assign xfer   = in_valid & in_ready;
    assign cnt_in = (in_data == '0) ? DEPTH : (ADDR_W+1)'(in_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = GET_CNT;
            GET_CNT: if (xfer) state_d = DATA;
            DATA:    if (xfer && remaining_q == CNT_ONE) state_d = FLUSH;
`ifdef MEM_LOADER_VERIFY_EN
            FLUSH:   state_d = VERIFY;
            VERIFY:  if (vcnt_q == CNT_ONE) state_d = DONE;
`else
            FLUSH:   state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == GET_CNT) || (state_q == DATA);
        busy     = (state_q != IDLE);
        cpu_hold = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        checksum_d  = checksum_q;
`ifdef MEM_LOADER_VERIFY_EN
        base_d       = base_q;
        count_d      = count_q;
        vcnt_d       = vcnt_q;
        rd_sum_d     = rd_sum_q;
        verify_err_d = verify_err_q;
`endif
        case (state_q)
            IDLE: if (xfer) begin
                ptr_d      = ADDR_W'(in_data);
                checksum_d = '0;
`ifdef MEM_LOADER_VERIFY_EN
                base_d       = ADDR_W'(in_data);
                verify_err_d = 1'b0;
`endif
            end
            GET_CNT: if (xfer) begin
                remaining_d = cnt_in;
`ifdef MEM_LOADER_VERIFY_EN
                count_d     = cnt_in;
`endif
            end
            DATA: if (xfer) begin
                mem_addr_d  = ptr_q;
                mem_wdata_d = in_data;
                mem_write_d = 1'b1;
                ptr_d       = ptr_q + ADDR_W'(1);
                checksum_d  = checksum_q + in_data;
                remaining_d = remaining_q - CNT_ONE;
            end
`ifdef MEM_LOADER_VERIFY_EN
            // The last write still lands on this edge using the old address.
            FLUSH: begin
                mem_addr_d = base_q;
                rd_sum_d   = '0;
                vcnt_d     = count_q;
            end
            VERIFY: begin
                rd_sum_d   = rd_sum_q + mem_rdata;
                mem_addr_d = mem_addr_q + ADDR_W'(1);
                vcnt_d     = vcnt_q - CNT_ONE;
                if (vcnt_q == CNT_ONE) verify_err_d = (rd_sum_d != checksum_q);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            remaining_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            checksum_q   <= '0;
`ifdef MEM_LOADER_VERIFY_EN
            base_q       <= '0;
            count_q      <= '0;
            vcnt_q       <= '0;
            rd_sum_q     <= '0;
            verify_err_q <= 1'b0;
`endif
        end else begin
            ptr_q        <= ptr_d;
            remaining_q  <= remaining_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            checksum_q   <= checksum_d;
`ifdef MEM_LOADER_VERIFY_EN
            base_q       <= base_d;
            count_q      <= count_d;
            vcnt_q       <= vcnt_d;
            rd_sum_q     <= rd_sum_d;
            verify_err_q <= verify_err_d;
`endif
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign checksum  = checksum_q;
`ifdef MEM_LOADER_VERIFY_EN
    assign verify_err = verify_err_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: frames are driven into the loader, a RAM model sits on its memory port,
// and results are compared with an array model filled directly from each frame.
module tb_mem_loader;

`ifdef MEM_LOADER_VERIFY_EN
    localparam bit VERIFY_BUILD = 1'b1;
`else
    localparam bit VERIFY_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, checksum;
    logic       mem_write, cpu_hold, busy, done, verify_err;

    logic [7:0] ram     [0:255] = '{default: 8'h00};
    logic [7:0] exp_ram [0:255] = '{default: 8'h00};
    logic [7:0] frame_data [0:255];
    logic       corrupt_go = 1'b0;
    logic [7:0] corrupt_addr = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;

    // Observations gathered by run_frame for the test tasks to judge.
    int         r_lat, r_proto_bad, r_hold_bad, r_wr_bad, r_writes;
    logic [7:0] r_sum;
    logic       r_verr, r_idle_after;

    always #5 clk = ~clk;

    mem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .checksum(checksum), .verify_err(verify_err)
    );

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        if (corrupt_go) ram[corrupt_addr] <= ram[corrupt_addr] ^ 8'hFF;
    end

    always @(negedge clk) if (mem_write === 1'b1) wr_count++;

    function automatic logic [7:0] model_frame(input logic [7:0] base, input int n);
        int sum = 0;
        for (int i = 0; i < n; i++) begin
            exp_ram[(int'(base) + i) % 256] = frame_data[i];
            sum += int'(frame_data[i]);
        end
        return 8'(sum % 256);
    endfunction

    function automatic int ram_diff();
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) bad++;
        return bad;
    endfunction

    function automatic logic [7:0] stream_byte(input logic [7:0] base, input logic [7:0] cnt_b, input int idx);
        if (idx == 0) return base;
        if (idx == 1) return cnt_b;
        return frame_data[idx-2];
    endfunction

    // mode 0: in_valid held high, 1: toggled every cycle, 2: random gaps.
    // A byte (0xA5) is offered throughout FLUSH..DONE and must not be taken.
    task automatic run_frame(input logic [7:0] base, input logic [7:0] cnt_b, input int mode, input bit corrupt);
        int n = (cnt_b == 8'h00) ? 256 : int'(cnt_b);
        int idx = 0, cyc = 0, prev = -1, wr0 = wr_count;
        bit v;
        r_lat = -1; r_proto_bad = 0; r_hold_bad = 0; r_wr_bad = 0;
        r_sum = 8'hxx; r_verr = 1'bx; r_idle_after = 1'b0;
        while (idx < n + 2 && cyc < 3000) begin
            @(negedge clk);
            if (busy !== (idx > 0) || cpu_hold !== (idx > 0)) r_hold_bad++;
            if (in_ready !== 1'b1 || done !== 1'b0) r_proto_bad++;
            if (mem_write !== (prev >= 2)) r_wr_bad++;
            else if (prev >= 2 && (mem_addr !== 8'(int'(base) + prev - 2) || mem_wdata !== frame_data[prev-2])) r_wr_bad++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = stream_byte(base, cnt_b, idx);
            if (v && in_ready === 1'b1) begin prev = idx; idx++; end
            else prev = -1;
            cyc++;
        end
        for (int d = 1; d <= 600 && idx == n + 2; d++) begin
            @(negedge clk);
            in_valid = (r_lat < 0);
            in_data  = 8'hA5;
            corrupt_addr = 8'(int'(base) + 1);
            corrupt_go   = corrupt && (d == 2);
            if (d == 1) begin
                if (mem_write !== 1'b1 || mem_addr !== 8'(int'(base) + n - 1) || mem_wdata !== frame_data[n-1]) r_wr_bad++;
            end else if (mem_write !== 1'b0) r_wr_bad++;
            if (r_lat < 0) begin
                if (in_ready !== 1'b0) r_proto_bad++;
                if (busy !== 1'b1 || cpu_hold !== 1'b1) r_hold_bad++;
                if (done === 1'b1) begin r_lat = d; r_sum = checksum; r_verr = verify_err; end
            end else begin
                r_idle_after = (busy === 1'b0 && cpu_hold === 1'b0 && in_ready === 1'b1 && done === 1'b0);
                break;
            end
        end
        in_valid = 1'b0;
        corrupt_go = 1'b0;
        r_writes = wr_count - wr0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_addr !== 8'h00) $display("FAIL reset mem_addr: got %h want 00", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 8'h00) $display("FAIL reset mem_wdata: got %h want 00", mem_wdata); else n_pass++;
        n_checks++; if (mem_write !== 1'b0) $display("FAIL reset mem_write: got %b want 0", mem_write); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset done: got %b want 0", done); else n_pass++;
        n_checks++; if (checksum !== 8'h00) $display("FAIL reset checksum: got %h want 00", checksum); else n_pass++;
        n_checks++; if (verify_err !== 1'b0) $display("FAIL reset verify_err: got %b want 0", verify_err); else n_pass++;
        n_checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0) $display("FAIL reset busy/hold: got %b%b want 00", busy, cpu_hold); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] es;
        frame_data[0] = 8'h11; frame_data[1] = 8'h22; frame_data[2] = 8'h33;
        es = model_frame(8'h00, 3);
        run_frame(8'h00, 8'h03, 0, 1'b0);
        n_checks++; if (r_lat !== (VERIFY_BUILD ? 5 : 2)) $display("FAIL basic done_latency: got %0d want %0d", r_lat, VERIFY_BUILD ? 5 : 2); else n_pass++;
        n_checks++; if (r_sum !== 8'h66 || es !== 8'h66) $display("FAIL basic checksum: got %h want 66", r_sum); else n_pass++;
        n_checks++; if (r_hold_bad !== 0) $display("FAIL basic cpu_hold: got %0d bad cycles want 0", r_hold_bad); else n_pass++;
        n_checks++; if (r_wr_bad !== 0 || r_writes !== 3) $display("FAIL basic writes: got %0d writes (%0d bad) want 3 (0 bad)", r_writes, r_wr_bad); else n_pass++;
        n_checks++; if (ram_diff() !== 0) $display("FAIL basic ram: got %0d wrong locations want 0", ram_diff()); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] es;
        for (int i = 0; i < 4; i++) frame_data[i] = 8'(i + 1);
        es = model_frame(8'hFE, 4);
        run_frame(8'hFE, 8'h04, 0, 1'b0);
        n_checks++; if (r_sum !== es) $display("FAIL wrap checksum: got %h want %h", r_sum, es); else n_pass++;
        n_checks++; if (ram[8'hFF] !== 8'h02 || ram[8'h00] !== 8'h03 || ram[8'h01] !== 8'h04) $display("FAIL wrap ram: got FF=%h 00=%h 01=%h want 02 03 04", ram[8'hFF], ram[8'h00], ram[8'h01]); else n_pass++;
        n_checks++; if (ram_diff() !== 0 || r_wr_bad !== 0) $display("FAIL wrap contents: got %0d wrong / %0d bad writes want 0", ram_diff(), r_wr_bad); else n_pass++;
    endtask

    task automatic test_full_page();
        logic [7:0] base = 8'($urandom_range(0, 255));
        logic [7:0] es;
        for (int i = 0; i < 256; i++) frame_data[i] = 8'(i);
        es = model_frame(base, 256);
        run_frame(base, 8'h00, 0, 1'b0);
        n_checks++; if (r_writes !== 256) $display("FAIL full writes: got %0d want 256", r_writes); else n_pass++;
        n_checks++; if (r_sum !== 8'h80 || es !== 8'h80) $display("FAIL full checksum: got %h want 80", r_sum); else n_pass++;
        n_checks++; if (ram_diff() !== 0) $display("FAIL full ram: got %0d wrong locations want 0", ram_diff()); else n_pass++;
        n_checks++; if (r_lat !== (VERIFY_BUILD ? 258 : 2)) $display("FAIL full done_latency: got %0d want %0d", r_lat, VERIFY_BUILD ? 258 : 2); else n_pass++;
    endtask

    task automatic test_toggle();
        logic [7:0] base = 8'($urandom_range(0, 255));
        logic [7:0] es;
        for (int i = 0; i < 7; i++) frame_data[i] = 8'($urandom);
        es = model_frame(base, 7);
        run_frame(base, 8'h07, 1, 1'b0);
        n_checks++; if (r_wr_bad !== 0 || r_writes !== 7) $display("FAIL toggle writes: got %0d writes (%0d bad) want 7 (0 bad)", r_writes, r_wr_bad); else n_pass++;
        n_checks++; if (r_proto_bad !== 0) $display("FAIL toggle in_ready: got %0d bad cycles want 0", r_proto_bad); else n_pass++;
        n_checks++; if (r_idle_after !== 1'b1) $display("FAIL toggle idle_after_done: got %b want 1", r_idle_after); else n_pass++;
        n_checks++; if (r_sum !== es || ram_diff() !== 0) $display("FAIL toggle result: got sum %h (%0d wrong) want %h (0 wrong)", r_sum, ram_diff(), es); else n_pass++;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 5; f++) begin
            logic [7:0] base = 8'($urandom_range(0, 255));
            int n = $urandom_range(1, 24);
            logic [7:0] es;
            for (int i = 0; i < n; i++) frame_data[i] = 8'($urandom);
            es = model_frame(base, n);
            run_frame(base, 8'(n), 2, 1'b0);
            n_checks++; if (r_sum !== es) $display("FAIL random%0d checksum: got %h want %h", f, r_sum, es); else n_pass++;
            n_checks++; if (r_lat !== (VERIFY_BUILD ? 2 + n : 2)) $display("FAIL random%0d done_latency: got %0d want %0d", f, r_lat, VERIFY_BUILD ? 2 + n : 2); else n_pass++;
            n_checks++; if (r_verr !== 1'b0) $display("FAIL random%0d verify_err: got %b want 0", f, r_verr); else n_pass++;
            n_checks++; if (r_wr_bad + r_proto_bad + r_hold_bad !== 0 || r_writes !== n || r_idle_after !== 1'b1)
                $display("FAIL random%0d protocol: got %0d/%0d/%0d bad, %0d writes, idle %b want 0/0/0, %0d, 1", f, r_wr_bad, r_proto_bad, r_hold_bad, r_writes, r_idle_after, n);
            else n_pass++;
            n_checks++; if (ram_diff() !== 0) $display("FAIL random%0d ram: got %0d wrong locations want 0", f, ram_diff()); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] base = 8'($urandom_range(0, 255));
        logic [7:0] es;
        int bad = 0;
        for (int i = 0; i < 5; i++) frame_data[i] = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = stream_byte(base, 8'h05, k);
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_write !== 1'b0) $display("FAIL midreset mem_write: got %b want 0", mem_write); else n_pass++;
        n_checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0) $display("FAIL midreset state: got busy %b hold %b done %b want 000", busy, cpu_hold, done); else n_pass++;
        n_checks++; if (mem_addr !== 8'h00 || checksum !== 8'h00) $display("FAIL midreset regs: got addr %h sum %h want 00 00", mem_addr, checksum); else n_pass++;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || mem_write !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL midreset quiet: got %0d active cycles want 0", bad); else n_pass++;
        es = model_frame(base, 2);
        n_checks++; if (ram_diff() !== 0) $display("FAIL midreset ram: got %0d wrong locations want 0 (sum %h)", ram_diff(), es); else n_pass++;
        base = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++) frame_data[i] = 8'($urandom);
        es = model_frame(base, 3);
        run_frame(base, 8'h03, 0, 1'b0);
        n_checks++; if (r_sum !== es || ram_diff() !== 0 || r_writes !== 3) $display("FAIL midreset recovery: got sum %h, %0d wrong, %0d writes want %h, 0, 3", r_sum, ram_diff(), r_writes, es); else n_pass++;
    endtask

`ifdef MEM_LOADER_VERIFY_EN
    task automatic test_verify();
        logic [7:0] base = 8'($urandom_range(0, 255));
        logic [7:0] es;
        for (int i = 0; i < 6; i++) frame_data[i] = 8'($urandom);
        es = model_frame(base, 6);
        exp_ram[8'(int'(base) + 1)] = exp_ram[8'(int'(base) + 1)] ^ 8'hFF;
        run_frame(base, 8'h06, 0, 1'b1);
        n_checks++; if (r_verr !== 1'b1) $display("FAIL verify corrupt: got verify_err %b want 1", r_verr); else n_pass++;
        n_checks++; if (r_sum !== es || r_lat !== 8) $display("FAIL verify corrupt_timing: got sum %h lat %0d want %h 8", r_sum, r_lat, es); else n_pass++;
        n_checks++; if (verify_err !== 1'b1) $display("FAIL verify held: got %b want 1", verify_err); else n_pass++;
        n_checks++; if (ram_diff() !== 0) $display("FAIL verify ram: got %0d wrong locations want 0", ram_diff()); else n_pass++;
        base = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) frame_data[i] = 8'($urandom);
        es = model_frame(base, 9);
        run_frame(base, 8'h09, 2, 1'b0);
        n_checks++; if (r_verr !== 1'b0 || r_lat !== 11) $display("FAIL verify clean: got verify_err %b lat %0d want 0 11", r_verr, r_lat); else n_pass++;
    endtask
`endif

    initial begin
        fork
            begin
                test_reset();
                test_basic();
                test_wrap();
                test_full_page();
                test_toggle();
                test_random_frames();
                test_mid_reset();
`ifdef MEM_LOADER_VERIFY_EN
                test_verify();
`endif
            end
            begin
                #2000000;
                $display("FAIL watchdog: got timeout want completion");
                n_checks++;
            end
        join_any
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
